credit_rx_buffer: RTL and testbench
===================================

Name: credit_rx_buffer

Overview:
- Receiver end of the latency-insensitive credit link. It buffers words sent by an upstream credit-counted sender and presents them to the local pearl.
- For every word the pearl consumes, it returns exactly one credit pulse, which drives the sender's credit-increment input.
- Depth equals the sender's credit count, so a compliant sender can never overflow it. Overflow is detected and flagged as a protocol error.

Parameters:
- N_CREDITS, 10, buffer depth in words; must match the sender's N_CREDITS; any value >= 1, not restricted to powers of 2.
- DATA_WIDTH, 32, payload width in bits.

Ports:
- clock  input  1  clock.
- reset  input  1  reset, synchronous, active-high.
- i_valid  input  1  link valid from the sender; one word per cycle while high.
- i_data  input  DATA_WIDTH  link payload, sampled when i_valid=1.
- o_valid  output  1  buffer non-empty; head word is presented on o_data.
- o_data  output  DATA_WIDTH  head-of-buffer word (show-ahead).
- i_ready  input  1  pearl consumes the head word this cycle when o_valid=1.
- o_credit  output  1  single-cycle credit-return pulse to the sender's increment input.
- o_occupancy  output  $clog2(N_CREDITS)+1  number of stored words.
- o_overflow  output  1  sticky protocol-error flag.

Behaviour:
- Storage: N_CREDITS x DATA_WIDTH array, with write pointer wr_ptr, read pointer rd_ptr and counter count (width $clog2(N_CREDITS)+1).
- Pointer wrap: each pointer advances 0..N_CREDITS-1 and wraps to 0 explicitly (no power-of-2 modulo).
- pop = o_valid & i_ready. i_ready while empty is ignored: no pointer move, no credit.
- push = i_valid & ((count < N_CREDITS) | pop). Push while full is accepted only when a pop happens in the same cycle.
- drop = i_valid & (count == N_CREDITS) & !pop:
  - word discarded;
  - no state change;
  - o_overflow set to 1 next cycle and held until reset.
- Count update:
  - push & !pop: +1.
  - pop & !push: -1.
  - both or neither: unchanged.
- o_valid = (count != 0). o_data = mem[rd_ptr], combinational from registered state. o_occupancy = count.
- Latency:
  - word pushed at cycle t is visible on o_valid/o_data at t+1 if the buffer was empty;
  - otherwise it appears in FIFO order.
- Credit return: o_credit registered, o_credit(t+1) = pop(t). Exactly one pulse per consumed word; no coalescing, no losses. Back-to-back pops give back-to-back pulses.
- Dropped words never generate credits.
- Reset values:
  - wr_ptr = rd_ptr = count = 0;
  - o_valid = 0, o_credit = 0, o_overflow = 0, o_occupancy = 0;
  - o_data undefined, mem contents not cleared.
- Reset mid-operation discards all stored words. No credits are returned for them; the sender resets to N_CREDITS concurrently.
- Invariant for a compliant sender: count + outstanding credit pulses in flight <= N_CREDITS.

Test Plan:
- Reset, then N_CREDITS=10; push D0..D9 on 10 consecutive cycles with i_ready=0 -> o_occupancy=10, o_valid=1, o_data=D0, o_credit never pulses, o_overflow=0.
- From full, i_ready=1 for 10 cycles -> o_data steps D0..D9 in order; o_credit high for 10 consecutive cycles, starting one cycle after the first pop; o_occupancy returns to 0, o_valid=0.
- Empty buffer: push X at cycle t with i_ready held 1 -> o_valid=1, o_data=X at t+1; pop at t+1; o_credit=1 at t+2 only; o_occupancy back to 0.
- Full (10) with simultaneous i_valid=1 (Y) and i_ready=1 for 25 cycles -> occupancy stays 10, 25 credit pulses, no overflow, FIFO order preserved across 2+ pointer wraps.
- Full with i_valid=1 and i_ready=0 -> word dropped, o_occupancy stays 10, o_overflow=1 next cycle and stays 1 after later pops; clears only on reset.
- Reset asserted with 5 words stored and a pop in progress -> next cycle o_valid=0, o_occupancy=0, o_credit=0, o_overflow=0; a subsequent push of Z gives o_data=Z.

Source files
------------

// File: rtl/credit_rx_buffer.sv
// credit_rx_buffer: receive-side buffer of the credit link.
// Stores words from a credit-counted sender. Shows the head word to the pearl
// and returns one registered credit pulse for every word the pearl consumes.
module credit_rx_buffer #(
  parameter int N_CREDITS  = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           i_valid,
  input  logic [DATA_WIDTH-1:0]          i_data,
  output logic                           o_valid,
  output logic [DATA_WIDTH-1:0]          o_data,
  input  logic                           i_ready,
  output logic                           o_credit,
  output logic [$clog2(N_CREDITS):0]     o_occupancy,
  output logic                           o_overflow
);

  localparam int CW = $clog2(N_CREDITS) + 1;
  // Keep at least one pointer bit so the pointer has a width when N_CREDITS is 1.
  localparam int PW = (N_CREDITS > 1) ? $clog2(N_CREDITS) : 1;

  localparam logic [CW-1:0] FULL_CNT = CW'(N_CREDITS);
  localparam logic [PW-1:0] LAST_PTR = PW'(N_CREDITS - 1);

  logic [DATA_WIDTH-1:0] mem_q [N_CREDITS];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          credit_q, credit_d;
  logic          overflow_q, overflow_d;

  logic pop;
  logic push;
  logic drop;

  // Handshake decode. A pop frees a slot in the same cycle, so a full buffer
  // can still accept a word when the pearl consumes one at the same time.
  always_comb begin
    pop  = (count_q != '0) & i_ready;
    push = i_valid & ((count_q < FULL_CNT) | pop);
    drop = i_valid & (count_q == FULL_CNT) & ~pop;
  end

  // Next-state computation. Pointers wrap explicitly because the depth need
  // not be a power of two.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    credit_d   = pop;
    overflow_d = overflow_q | drop;

    if (push) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
    end

    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  // Control state register. Reset drops stored words without returning
  // credits; the sender restores its own credit count at the same time.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      credit_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      credit_q   <= credit_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array write; contents are deliberately left uncleared by reset.
  always_ff @(posedge clock) begin
    if (push && !reset) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  // Outputs come straight from registered state.
  always_comb begin
    o_valid     = (count_q != '0);
    o_data      = mem_q[rd_ptr_q];
    o_occupancy = count_q;
    o_credit    = credit_q;
    o_overflow  = overflow_q;
  end

endmodule

// File: tb/tb_credit_rx_buffer.sv
// Directed bench for credit_rx_buffer with N_CREDITS=10, DATA_WIDTH=32.
module tb_credit_rx_buffer;

  localparam int N  = 10;
  localparam int DW = 32;

  logic          clock;
  logic          reset;
  logic          i_valid;
  logic [DW-1:0] i_data;
  logic          o_valid;
  logic [DW-1:0] o_data;
  logic          i_ready;
  logic          o_credit;
  logic [4:0]    o_occupancy;
  logic          o_overflow;

  int errors = 0;
  int checks = 0;

  credit_rx_buffer #(.N_CREDITS(N), .DATA_WIDTH(DW)) dut (
    .clock       (clock),
    .reset       (reset),
    .i_valid     (i_valid),
    .i_data      (i_data),
    .o_valid     (o_valid),
    .o_data      (o_data),
    .i_ready     (i_ready),
    .o_credit    (o_credit),
    .o_occupancy (o_occupancy),
    .o_overflow  (o_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One clock edge; outputs are then sampled 1ns after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset   = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    i_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_valid", o_valid, 0);
    chk("rst_occ", o_occupancy, 0);
    chk("rst_credit", o_credit, 0);
    chk("rst_ovf", o_overflow, 0);

    // Fill D0..D9 with no consumer
    for (int i = 0; i < N; i++) begin
      i_valid = 1'b1;
      i_data  = 32'hA000_0000 + i;
      tick();
      chk("fill_occ", o_occupancy, i + 1);
      chk("fill_credit", o_credit, 0);
      chk("fill_valid", o_valid, 1);
      chk("fill_head", o_data, 32'hA000_0000);
    end
    i_valid = 1'b0;
    chk("full_ovf", o_overflow, 0);

    // Drain from full: FIFO order, credits on 10 consecutive cycles
    i_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      chk("drain_data", o_data, 32'hA000_0000 + i);
      chk("drain_valid", o_valid, 1);
      tick();
      chk("drain_credit", o_credit, 1);
      chk("drain_occ", o_occupancy, N - 1 - i);
    end
    chk("drained_valid", o_valid, 0);
    tick();
    chk("empty_ready_credit", o_credit, 0);
    chk("empty_ready_occ", o_occupancy, 0);

    // Single word into empty buffer with consumer ready
    i_valid = 1'b1;
    i_data  = 32'h1234_5678;
    tick();
    i_valid = 1'b0;
    chk("single_valid", o_valid, 1);
    chk("single_data", o_data, 32'h1234_5678);
    chk("single_credit0", o_credit, 0);
    chk("single_occ1", o_occupancy, 1);
    tick();
    chk("single_credit1", o_credit, 1);
    chk("single_occ0", o_occupancy, 0);
    chk("single_valid0", o_valid, 0);
    tick();
    chk("single_credit2", o_credit, 0);

    // Fill again F0..F9, then stream 25 words through the full buffer
    i_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      i_valid = 1'b1;
      i_data  = 32'hB000_0000 + i;
      tick();
    end
    chk("refill_occ", o_occupancy, N);
    i_ready = 1'b1;
    for (int k = 0; k < 25; k++) begin
      i_data = 32'hC000_0000 + k;
      chk("stream_data", o_data, (k < N) ? (32'hB000_0000 + k) : (32'hC000_0000 + k - N));
      tick();
      chk("stream_credit", o_credit, 1);
      chk("stream_occ", o_occupancy, N);
      chk("stream_ovf", o_overflow, 0);
    end

    // Push while full with no pop: dropped, overflow sticks
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_data  = 32'hDEAD_BEEF;
    tick();
    i_valid = 1'b0;
    chk("drop_occ", o_occupancy, N);
    chk("drop_ovf", o_overflow, 1);
    chk("drop_credit", o_credit, 0);
    i_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      chk("post_drop_data", o_data, 32'hC000_0000 + 15 + i);
      tick();
      chk("post_drop_credit", o_credit, 1);
      chk("post_drop_ovf", o_overflow, 1);
    end
    tick();
    chk("empty_ovf_sticky", o_overflow, 1);
    chk("empty_occ", o_occupancy, 0);

    // Five words stored, reset during a pop
    i_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      i_valid = 1'b1;
      i_data  = 32'hE000_0000 + i;
      tick();
    end
    i_valid = 1'b0;
    chk("pre_rst_occ", o_occupancy, 5);
    i_ready = 1'b1;
    reset   = 1'b1;
    tick();
    reset   = 1'b0;
    i_ready = 1'b0;
    chk("midrst_valid", o_valid, 0);
    chk("midrst_occ", o_occupancy, 0);
    chk("midrst_credit", o_credit, 0);
    chk("midrst_ovf", o_overflow, 0);
    i_valid = 1'b1;
    i_data  = 32'h5A5A_0F0F;
    tick();
    i_valid = 1'b0;
    chk("post_rst_data", o_data, 32'h5A5A_0F0F);
    chk("post_rst_valid", o_valid, 1);
    chk("post_rst_occ", o_occupancy, 1);
    tick();
    chk("post_rst_credit", o_credit, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
